// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte per frame from a registered-read FIFO and
// serializes it as a UART frame (start, data LSB first, optional parity, stop).
module fifo_uart_tx #(
  parameter int DSIZE        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tx_en,
  input  logic             fifo_empty,
  input  logic [DSIZE-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DSIZE + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DSIZE - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PAR, STOP} state_t;

  state_t            state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg;
  logic [BIT_W-1:0]  bit_reg;
  logic              stop_reg;
  logic [DSIZE-1:0]  shift_reg;
  logic              parity_reg;
  logic              tx_reg, tx_next;
  logic              frame_done_reg;
  logic              baud_last;
  logic              stop_last;

  assign baud_last = (baud_reg == BAUD_LAST);
  assign stop_last = baud_last && ((STOP_BITS == 1) || stop_reg);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      tx_reg         <= 1'b1;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tx_reg         <= tx_next;
      frame_done_reg <= (state_reg == STOP) && (state_next == IDLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (tx_en && !fifo_empty) state_next = FETCH;
      FETCH:   state_next = LOAD;
      LOAD:    state_next = START;
      START:   if (baud_last) state_next = DATA;
      DATA:    if (baud_last && (bit_reg == BIT_LAST))
                 state_next = (PARITY != 0) ? PAR : STOP;
      PAR:     if (baud_last) state_next = STOP;
      STOP:    if (stop_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx is computed from the upcoming state so each bit starts on the state's first cycle.
  always_comb begin
    tx_next    = 1'b1;
    fifo_rd_en = (state_reg == FETCH);
    busy       = (state_reg != IDLE);
    frame_done = frame_done_reg;
    tx         = tx_reg;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = ((state_reg == DATA) && baud_last) ? shift_reg[1] : shift_reg[0];
      PAR:     tx_next = parity_reg;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      baud_reg   <= '0;
      bit_reg    <= '0;
      stop_reg   <= 1'b0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
    end else begin
      if ((state_next != state_reg) || baud_last)
        baud_reg <= '0;
      else if (state_reg inside {START, DATA, PAR, STOP})
        baud_reg <= baud_reg + 1'b1;

      if (state_reg != DATA)
        bit_reg <= '0;
      else if (baud_last)
        bit_reg <= bit_reg + 1'b1;

      if (state_reg != STOP)
        stop_reg <= 1'b0;
      else if (baud_last)
        stop_reg <= ~stop_reg;

      if (state_reg == LOAD) begin
        shift_reg  <= fifo_dout;
        parity_reg <= (PARITY == 2) ? ~(^fifo_dout) : (^fifo_dout);
      end else if ((state_reg == DATA) && baud_last) begin
        shift_reg  <= shift_reg >> 1;
      end
    end
  end

endmodule
